// File: rtl/house_sorter.sv
// House sorter: spins a player's house display through G->S->R->H for a fixed number of
// steps, then locks it to a pseudo-random house taken from a free-running LFSR.
module house_sorter #(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned SPIN_STEPS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       player,
    input  logic       show_lb,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    output logic       R1,
    output logic       G1,
    output logic       S1,
    output logic       H1,
    output logic       R2,
    output logic       G2,
    output logic       S2,
    output logic       H2,
    output logic       Rl,
    output logic       Gl,
    output logic       Sl,
    output logic       Hl,
    output logic       leaderboard,
    output logic       player_sel,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StSpin, StLock, StDone} state_e;

    localparam logic [3:0] FRAME_LAST = 4'(STEP_FRAMES - 1);
    localparam logic [4:0] STEP_LAST  = 5'(SPIN_STEPS - 1);

    state_e      state_q, state_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  frame_q, frame_d;
    logic [4:0]  step_q, step_d;
    logic        sel_q, sel_d;
    // House registers are one-hot indexed by house code: bit0=G, bit1=S, bit2=R, bit3=H.
    logic [3:0]  house1_q, house1_d;
    logic [3:0]  house2_q, house2_d;
    logic [3:0]  lb_house_q, lb_house_d;
    logic        lb_q, lb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  cur_house;
    logic [3:0]  new_house;
    logic        write_house;
    logic        write_sel;

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        step_d      = step_q;
        sel_d       = sel_q;
        house1_d    = house1_q;
        house2_d    = house2_q;
        cur_house   = sel_q ? house2_q : house1_q;
        new_house   = cur_house;
        write_house = 1'b0;
        write_sel   = sel_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StSpin;
                    sel_d       = player;
                    frame_d     = '0;
                    step_d      = '0;
                    new_house   = 4'b0001;
                    write_house = 1'b1;
                    write_sel   = player;
                end
            end
            StSpin: begin
                if (frame_tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_d = '0;
                        if (step_q == STEP_LAST) begin
                            state_d = StLock;
                        end else begin
                            step_d      = step_q + 5'd1;
                            // Rotating the one-hot left is code+1: G->S->R->H->G.
                            new_house   = {cur_house[2:0], cur_house[3]};
                            write_house = 1'b1;
                        end
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end
            end
            StLock: begin
                new_house   = 4'b0001 << lfsr_q[1:0];
                write_house = 1'b1;
                step_d      = '0;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (write_house) begin
            if (write_sel) begin
                house2_d = new_house;
            end else begin
                house1_d = new_house;
            end
        end
    end

    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        busy_d     = (state_d == StSpin) || (state_d == StLock);
        done_d     = (state_d == StDone);
        // busy_d already covers an accepted start, so start wins over show_lb.
        lb_d       = show_lb && !busy_d;
        lb_house_d = (score2 > score1) ? house2_q : house1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lfsr_q     <= 8'h01;
            frame_q    <= '0;
            step_q     <= '0;
            sel_q      <= 1'b0;
            house1_q   <= '0;
            house2_q   <= '0;
            lb_house_q <= '0;
            lb_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            frame_q    <= frame_d;
            step_q     <= step_d;
            sel_q      <= sel_d;
            house1_q   <= house1_d;
            house2_q   <= house2_d;
            lb_house_q <= lb_house_d;
            lb_q       <= lb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign {H1, R1, S1, G1} = house1_q;
    assign {H2, R2, S2, G2} = house2_q;
    assign {Hl, Rl, Sl, Gl} = lb_house_q;
    assign leaderboard      = lb_q;
    assign player_sel       = sel_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_house_sorter.sv
// Self-checking bench for house_sorter: directed sort scenarios with a scoreboard of
// expected displayed houses and an independent LFSR model for the lock value.
module tb_house_sorter;

    localparam int SF = 4;
    localparam int SS = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic start = 1'b0;
    logic player = 1'b0;
    logic show_lb = 1'b0;
    logic [7:0] score1 = 8'd0;
    logic [7:0] score2 = 8'd0;
    logic R1, G1, S1, H1, R2, G2, S2, H2, Rl, Gl, Sl, Hl;
    logic leaderboard, player_sel, busy, done;

    logic [3:0] grp1, grp2, grpl;
    assign grp1 = {H1, R1, S1, G1};
    assign grp2 = {H2, R2, S2, G2};
    assign grpl = {Hl, Rl, Sl, Gl};

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] h_exp[2];
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'h01;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    house_sorter #(.STEP_FRAMES(SF), .SPIN_STEPS(SS)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .player(player),
        .show_lb(show_lb), .score1(score1), .score2(score2),
        .R1(R1), .G1(G1), .S1(S1), .H1(H1), .R2(R2), .G2(G2), .S2(S2), .H2(H2),
        .Rl(Rl), .Gl(Gl), .Sl(Sl), .Hl(Hl),
        .leaderboard(leaderboard), .player_sel(player_sel), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sort of player p; disturb pulses start and show_lb during the spin.
    task automatic run_sort(input logic p, input bit disturb);
        logic [3:0] cur_h, got, exp_h, lock_h;
        int pi, oi;
        pi = p ? 1 : 0;
        oi = p ? 0 : 1;
        start = 1'b1; player = p; show_lb = disturb;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || player_sel !== p || leaderboard !== 1'b0 || done !== 1'b0)
            $display("FAIL spin_entry: busy=%b sel=%b lb=%b done=%b, expected 1 %b 0 0",
                     busy, player_sel, leaderboard, done, p);
        got = p ? grp2 : grp1;
        checks++;
        if (got !== 4'b0001) begin
            errors++;
            $display("FAIL spin_first_house: got %b expected 0001", got);
        end
        cur_h = 4'b0001;
        for (int t = 1; t <= SF * SS; t++) begin
            for (int g = 0; g < 9; g++) begin
                start = disturb && (g == 3) && (t < 30);
                player = disturb ? ~p : p;
                step();
                start = 1'b0;
                got = p ? grp2 : grp1;
                checks++;
                if (busy !== 1'b1 || leaderboard !== 1'b0 || done !== 1'b0 ||
                    player_sel !== p || got !== cur_h) begin
                    errors++;
                    $display("FAIL spin_hold t=%0d: busy=%b lb=%b done=%b sel=%b house=%b, expected 1 0 0 %b %b",
                             t, busy, leaderboard, done, player_sel, got, p, cur_h);
                end
                checks++;
                if (!$onehot0(grp1) || !$onehot0(grp2) || !$onehot0(grpl)) begin
                    errors++;
                    $display("FAIL onehot: grp1=%b grp2=%b grpl=%b, expected one-hot or zero",
                             grp1, grp2, grpl);
                end
            end
            player = p;
            if (t < SF * SS) exp_q.push_back(4'b0001 << ((t / SF) % 4));
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (t < SF * SS) begin
                exp_h = exp_q.pop_front();
                got = p ? grp2 : grp1;
                checks++;
                if (got !== exp_h) begin
                    errors++;
                    $display("FAIL spin_advance t=%0d: got %b expected %b", t, got, exp_h);
                end
                cur_h = exp_h;
            end
        end
        // LOCK cycle: house not yet advanced past the last spin step.
        got = p ? grp2 : grp1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || leaderboard !== 1'b0 || got !== 4'b1000) begin
            errors++;
            $display("FAIL lock_cycle: busy=%b done=%b lb=%b house=%b, expected 1 0 0 1000",
                     busy, done, leaderboard, got);
        end
        lock_h = 4'b0001 << m_lfsr[1:0];
        exp_q.push_back(lock_h);
        step();
        got = p ? grp2 : grp1;
        exp_h = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || got !== exp_h) begin
            errors++;
            $display("FAIL done_cycle: done=%b busy=%b house=%b, expected 1 0 %b",
                     done, busy, got, exp_h);
        end
        h_exp[pi] = exp_h;
        checks++;
        got = p ? grp1 : grp2;
        if (got !== h_exp[oi]) begin
            errors++;
            $display("FAIL other_player_kept: got %b expected %b", got, h_exp[oi]);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b, expected 0 0", done, busy);
        end
        if (disturb) begin
            checks++;
            if (leaderboard !== 1'b1) begin
                errors++;
                $display("FAIL lb_after_done: got %b expected 1", leaderboard);
            end
            show_lb = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL no_queued_start: busy=%b expected 0", busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({grp1, grp2, grpl} !== 12'h000 || leaderboard !== 1'b0 || player_sel !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: houses=%b %b %b lb=%b sel=%b busy=%b done=%b, expected all 0",
                     grp1, grp2, grpl, leaderboard, player_sel, busy, done);
        end
        h_exp[0] = 4'b0000;
        h_exp[1] = 4'b0000;
    endtask

    task automatic test_single_sort();
        run_sort(1'b0, 1'b0);
    endtask

    task automatic test_both_players();
        run_sort(1'b1, 1'b0);
    endtask

    task automatic test_leaderboard();
        score1 = 8'd20; score2 = 8'd20; show_lb = 1'b1;
        step();
        checks++;
        if (leaderboard !== 1'b1 || grpl !== h_exp[0]) begin
            errors++;
            $display("FAIL lb_tie: lb=%b grpl=%b, expected 1 %b", leaderboard, grpl, h_exp[0]);
        end
        score2 = 8'd21;
        step();
        checks++;
        if (grpl !== h_exp[1]) begin
            errors++;
            $display("FAIL lb_p2_wins: grpl=%b expected %b", grpl, h_exp[1]);
        end
        show_lb = 1'b0;
        step();
        checks++;
        if (leaderboard !== 1'b0) begin
            errors++;
            $display("FAIL lb_off: got %b expected 0", leaderboard);
        end
    endtask

    task automatic test_ignore();
        run_sort(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_sort(1'b1, 1'b0);
        run_sort(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_spin();
        start = 1'b1; player = 1'b0;
        step();
        start = 1'b0;
        for (int t = 0; t < 5 * SF; t++) begin
            for (int g = 0; g < 9; g++) step();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || grp1 !== 4'b0010) begin
            errors++;
            $display("FAIL step5_state: busy=%b house=%b, expected 1 0010", busy, grp1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        h_exp[0] = 4'b0000;
        h_exp[1] = 4'b0000;
        checks++;
        if ({grp1, grp2, grpl} !== 12'h000 || busy !== 1'b0 || done !== 1'b0 ||
            leaderboard !== 1'b0 || player_sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_spin_reset: houses=%b %b %b busy=%b done=%b lb=%b sel=%b, expected all 0",
                     grp1, grp2, grpl, busy, done, leaderboard, player_sel);
        end
        for (int k = 0; k < 4; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            checks++;
            if (busy !== 1'b0 || grp1 !== 4'b0000) begin
                errors++;
                $display("FAIL idle_after_reset: busy=%b house=%b, expected 0 0000", busy, grp1);
            end
        end
        run_sort(1'b1, 1'b0);
    endtask

    task automatic test_unsorted_winner();
        score1 = 8'd50; score2 = 8'd10; show_lb = 1'b1;
        step();
        step();
        checks++;
        if (leaderboard !== 1'b1 || grpl !== 4'b0000) begin
            errors++;
            $display("FAIL unsorted_winner: lb=%b grpl=%b, expected 1 0000", leaderboard, grpl);
        end
        score2 = 8'd60;
        step();
        checks++;
        if (grpl !== h_exp[1]) begin
            errors++;
            $display("FAIL sorted_winner: grpl=%b expected %b", grpl, h_exp[1]);
        end
        show_lb = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_single_sort();
        test_both_players();
        test_leaderboard();
        test_ignore();
        test_back_to_back();
        test_reset_mid_spin();
        test_unsorted_winner();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
